// File: rtl/link_dispatcher_if.sv
// Link-side bundle of the receive dispatcher: incoming flits, FIFO write port, pops and credits.
// With LINK_DISPATCHER_DROP_CNT_EN defined the bundle also carries the 16-bit drop counter.
interface link_dispatcher_if #(
    parameter int N_REQUEST_SIGNAL = 6,
    parameter int N_BITS_POINTER   = $clog2(N_REQUEST_SIGNAL),
    parameter int FLIT_WIDTH       = 64,
    parameter int BUFFER_DEPTH     = 4,
    parameter int N_BITS_OCC       = $clog2(BUFFER_DEPTH + 1)
);
    logic                                   valid_i;
    logic [FLIT_WIDTH-1:0]                  flit_i;
    logic [N_BITS_POINTER-1:0]              channel_id_i;
    logic [FLIT_WIDTH-1:0]                  flit_o;
    logic [N_REQUEST_SIGNAL-1:0]            w_en_o;
    logic [N_REQUEST_SIGNAL-1:0]            pop_i;
    logic [N_REQUEST_SIGNAL-1:0]            credit_o;
    logic [N_REQUEST_SIGNAL*N_BITS_OCC-1:0] occupancy_o;
    logic                                   error_o;
`ifdef LINK_DISPATCHER_DROP_CNT_EN
    logic [15:0]                            drop_cnt_o;
`endif

    modport master (
        output valid_i, flit_i, channel_id_i, pop_i,
        input  flit_o, w_en_o, credit_o, occupancy_o, error_o
`ifdef LINK_DISPATCHER_DROP_CNT_EN
        , input drop_cnt_o
`endif
    );

    modport slave (
        input  valid_i, flit_i, channel_id_i, pop_i,
        output flit_o, w_en_o, credit_o, occupancy_o, error_o
`ifdef LINK_DISPATCHER_DROP_CNT_EN
        , output drop_cnt_o
`endif
    );
endinterface

// File: rtl/link_dispatcher.sv
// Steers link flits into per-channel receive FIFOs, tracks occupancy and returns credits upstream.
// Optional LINK_DISPATCHER_DROP_CNT_EN adds a saturating 16-bit dropped-flit counter.
module link_dispatcher #(
    parameter int N_REQUEST_SIGNAL = 6,
    parameter int N_BITS_POINTER   = $clog2(N_REQUEST_SIGNAL),
    parameter int FLIT_WIDTH       = 64,
    parameter int BUFFER_DEPTH     = 4,
    parameter int N_BITS_OCC       = $clog2(BUFFER_DEPTH + 1)
) (
    input logic              clk,
    input logic              rst,
    link_dispatcher_if.slave bus
);
    localparam logic [N_BITS_POINTER:0] N_CH = (N_BITS_POINTER + 1)'(N_REQUEST_SIGNAL);
    localparam logic [N_BITS_OCC-1:0]   FULL = N_BITS_OCC'(BUFFER_DEPTH);
    localparam logic [N_BITS_OCC-1:0]   ONE  = N_BITS_OCC'(1);

    logic [N_REQUEST_SIGNAL-1:0][N_BITS_OCC-1:0] occ_q;
    logic [FLIT_WIDTH-1:0]                       flit_q;
    logic [N_REQUEST_SIGNAL-1:0]                 w_en_q;
    logic [N_REQUEST_SIGNAL-1:0]                 credit_q;
    logic                                        error_q;

    logic [N_BITS_OCC-1:0]       occ_sel;
    logic                        in_range;
    logic                        accept;
    logic                        drop;
    logic                        underflow;
    logic [N_REQUEST_SIGNAL-1:0] wr_hit;
    logic [N_REQUEST_SIGNAL-1:0] pop_ok;

    always_comb begin
        // NOTE: every signal gets a default before the loops so no path leaves one unassigned (no latch).
        occ_sel   = '0;
        wr_hit    = '0;
        pop_ok    = '0;
        underflow = 1'b0;
        for (int k = 0; k < N_REQUEST_SIGNAL; k++) begin
            if (bus.channel_id_i == N_BITS_POINTER'(k)) occ_sel = occ_q[k];
            pop_ok[k] = bus.pop_i[k] && (occ_q[k] != '0);
            underflow = underflow | (bus.pop_i[k] && (occ_q[k] == '0));
        end
        // Full check uses pre-edge occupancy, so a same-cycle pop cannot rescue a full channel.
        in_range = {1'b0, bus.channel_id_i} < N_CH;
        accept   = bus.valid_i && in_range && (occ_sel < FULL);
        drop     = bus.valid_i && !accept;
        for (int k = 0; k < N_REQUEST_SIGNAL; k++) begin
            wr_hit[k] = accept && (bus.channel_id_i == N_BITS_POINTER'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments only; everything here is small enough to reset.
            flit_q   <= '0;
            w_en_q   <= '0;
            credit_q <= '0;
            error_q  <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (accept) flit_q <= bus.flit_i;
            w_en_q   <= wr_hit;
            credit_q <= pop_ok;
            error_q  <= error_q | drop | underflow;
            for (int k = 0; k < N_REQUEST_SIGNAL; k++) begin
                case ({wr_hit[k], pop_ok[k]})
                    2'b10:   occ_q[k] <= occ_q[k] + ONE;
                    2'b01:   occ_q[k] <= occ_q[k] - ONE;
                    default: occ_q[k] <= occ_q[k];
                endcase
            end
        end
    end

    assign bus.flit_o      = flit_q;
    assign bus.w_en_o      = w_en_q;
    assign bus.credit_o    = credit_q;
    assign bus.occupancy_o = occ_q;
    assign bus.error_o     = error_q;

`ifdef LINK_DISPATCHER_DROP_CNT_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign bus.drop_cnt_o = drop_cnt_q;
`endif
endmodule

// File: tb/tb_link_dispatcher.sv
// Scoreboard bench for link_dispatcher: directed scenarios then random traffic vs. a queue/array model.
// Drop-counter checks are active when LINK_DISPATCHER_DROP_CNT_EN is defined.
module tb_link_dispatcher;
    localparam int NCH   = 6;
    localparam int DEPTH = 4;

    typedef struct {
        logic [63:0] flit;
        logic [5:0]  w_en;
        logic [5:0]  credit;
        logic [17:0] occ;
        logic        err;
        logic [15:0] dcnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    link_dispatcher_if #(.N_REQUEST_SIGNAL(NCH), .FLIT_WIDTH(64), .BUFFER_DEPTH(DEPTH)) bus ();

    link_dispatcher #(.N_REQUEST_SIGNAL(NCH), .FLIT_WIDTH(64), .BUFFER_DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model state
    int          occ_m [NCH];
    logic [63:0] flit_m = '0;
    logic        err_m  = 1'b0;
    int          dcnt_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    task automatic step(input logic r, input logic v, input logic [2:0] id,
                        input logic [63:0] f, input logic [5:0] p);
        exp_t e;
        bit   acc;
        @(negedge clk);
        rst              = r;
        bus.valid_i      = v;
        bus.channel_id_i = id;
        bus.flit_i       = f;
        bus.pop_i        = p;
        e.w_en   = '0;
        e.credit = '0;
        if (!r) begin
            foreach (occ_m[k]) occ_m[k] = 0;
            flit_m = '0;
            err_m  = 1'b0;
            dcnt_m = 0;
        end else begin
            acc = v && (int'(id) < NCH) && (occ_m[int'(id) % NCH] < DEPTH);
            if (acc) begin
                e.w_en[id] = 1'b1;
                flit_m     = f;
            end else if (v) begin
                err_m = 1'b1;
                if (dcnt_m < 65535) dcnt_m++;
            end
            for (int k = 0; k < NCH; k++) begin
                if (p[k]) begin
                    if (occ_m[k] > 0) e.credit[k] = 1'b1;
                    else err_m = 1'b1;
                end
            end
            for (int k = 0; k < NCH; k++) begin
                occ_m[k] = occ_m[k] + int'(e.w_en[k]) - int'(e.credit[k]);
            end
        end
        e.flit = flit_m;
        e.err  = err_m;
        e.dcnt = 16'(dcnt_m);
        for (int k = 0; k < NCH; k++) e.occ[k*3 +: 3] = 3'(occ_m[k]);
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 64'd0, 6'd0);
    endtask

    // Monitor: one expected entry per clock edge after stimulus started.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("w_en", 64'(bus.w_en_o), 64'(e.w_en));
                check("credit", 64'(bus.credit_o), 64'(e.credit));
                check("occupancy", 64'(bus.occupancy_o), 64'(e.occ));
                check("error", 64'(bus.error_o), 64'(e.err));
                check("flit", bus.flit_o, e.flit);
`ifdef LINK_DISPATCHER_DROP_CNT_EN
                check("drop_cnt", 64'(bus.drop_cnt_o), 64'(e.dcnt));
`endif
            end
        end
    end

    initial begin
        bus.valid_i      = 1'b0;
        bus.flit_i       = '0;
        bus.channel_id_i = '0;
        bus.pop_i        = '0;

        // Reset held with valid high
        step(1'b0, 1'b1, 3'd3, 64'hDEAD, 6'd0);
        step(1'b0, 1'b1, 3'd3, 64'hDEAD, 6'd0);
        // Single write
        step(1'b1, 1'b1, 3'd3, 64'hA5, 6'd0);
        // Fill and overflow channel 0
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 3'd0, 64'(100 + i), 6'd0);
        // Pop/credit on channel 2
        step(1'b1, 1'b1, 3'd2, 64'h22, 6'd0);
        step(1'b1, 1'b1, 3'd2, 64'h23, 6'd0);
        step(1'b1, 1'b0, 3'd0, 64'd0, 6'b000100);
        step(1'b1, 1'b0, 3'd0, 64'd0, 6'b000100);
        idle(2);
        // Write to full channel 1 with a same-cycle pop
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 3'd1, 64'(200 + i), 6'd0);
        step(1'b1, 1'b1, 3'd1, 64'hBAD1, 6'b000010);
        // Write and pop together on half-full channel 4
        step(1'b1, 1'b1, 3'd4, 64'h40, 6'd0);
        step(1'b1, 1'b1, 3'd4, 64'h41, 6'd0);
        step(1'b1, 1'b1, 3'd4, 64'h42, 6'b010000);
        idle(1);
        // Out-of-range id after a clean reset
        step(1'b0, 1'b0, 3'd0, 64'd0, 6'd0);
        step(1'b1, 1'b1, 3'd7, 64'h77, 6'd0);
        idle(1);
        // Underflow pop after a clean reset
        step(1'b0, 1'b0, 3'd0, 64'd0, 6'd0);
        step(1'b1, 1'b0, 3'd0, 64'd0, 6'b100000);
        idle(2);

        // Random traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            logic       r;
            logic       v;
            logic [2:0] id;
            logic [5:0] p;
            r  = ($urandom_range(0, 299) != 0);
            v  = ($urandom_range(0, 3) != 0);
            id = ($urandom_range(0, 15) == 0) ? 3'(6 + $urandom_range(0, 1))
                                               : 3'($urandom_range(0, NCH - 1));
            p  = 6'($urandom) & 6'($urandom);
            step(r, v, id, {$urandom, $urandom}, p);
        end
        idle(2);

        @(posedge clk);
        #2;
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
